// File: rtl/multibyte_add_pkg.sv
// rtl/multibyte_add_pkg.sv - shared constants for the multi-byte add/sub controller
package multibyte_add_pkg;

    localparam int BYTE_W         = 8;
    localparam int NBYTES_DEFAULT = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/multibyte_add_ctrl_adder.sv
// rtl/multibyte_add_ctrl_adder.sv - 8-bit carry-select adder shared by all byte lanes
module carry_select_adder
    import multibyte_add_pkg::*;
(
    input  logic [BYTE_W-1:0] din_a,
    input  logic [BYTE_W-1:0] din_b,
    input  logic              cin,
    output logic [BYTE_W-1:0] sum,
    output logic              cout
);

    localparam int H = BYTE_W / 2;

    logic [H:0] lo;
    logic [H:0] hi0;
    logic [H:0] hi1;

    // Upper nibble is precomputed for both carry values; the low carry only selects.
    assign lo  = {1'b0, din_a[H-1:0]} + {1'b0, din_b[H-1:0]} + {{H{1'b0}}, cin};
    assign hi0 = {1'b0, din_a[BYTE_W-1:H]} + {1'b0, din_b[BYTE_W-1:H]};
    assign hi1 = {1'b0, din_a[BYTE_W-1:H]} + {1'b0, din_b[BYTE_W-1:H]} + {{H{1'b0}}, 1'b1};

    assign sum  = {(lo[H] ? hi1[H-1:0] : hi0[H-1:0]), lo[H-1:0]};
    assign cout = lo[H] ? hi1[H] : hi0[H];

endmodule

// File: rtl/multibyte_add_ctrl.sv
// rtl/multibyte_add_ctrl.sv - NBYTES-wide add/sub sequenced through one 8-bit adder, LSB first
module multibyte_add_ctrl
    import multibyte_add_pkg::*;
#(
    parameter int NBYTES = NBYTES_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   sub,
    input  logic                   cin,
    input  logic [BYTE_W*NBYTES-1:0] a,
    input  logic [BYTE_W*NBYTES-1:0] b,
    output logic                   busy,
    output logic                   done,
    output logic [BYTE_W*NBYTES-1:0] sum,
    output logic                   cout,
    output logic                   ovf
);

    localparam int W     = BYTE_W * NBYTES;
    localparam int IDX_W = $clog2(NBYTES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    logic [1:0]        state;
    logic [IDX_W-1:0]  idx;
    logic              carry_reg;
    logic [W-1:0]      a_reg;
    logic [W-1:0]      b_reg;
    logic [W-1:0]      sum_reg;
    logic              cout_reg;
    logic              ovf_reg;

    logic [BYTE_W-1:0] add_sum;
    logic              add_cout;

    carry_select_adder u_adder (
        .din_a (a_reg[idx*BYTE_W +: BYTE_W]),
        .din_b (b_reg[idx*BYTE_W +: BYTE_W]),
        .cin   (carry_reg),
        .sum   (add_sum),
        .cout  (add_cout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            idx       <= '0;
            carry_reg <= 1'b0;
            a_reg     <= '0;
            b_reg     <= '0;
            sum_reg   <= '0;
            cout_reg  <= 1'b0;
            ovf_reg   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        // Subtract is a + ~b + 1, so the borrow lives in the initial carry.
                        a_reg     <= a;
                        b_reg     <= sub ? ~b : b;
                        carry_reg <= sub ? 1'b1 : cin;
                        idx       <= '0;
                        sum_reg   <= '0;
                        state     <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    sum_reg[idx*BYTE_W +: BYTE_W] <= add_sum;
                    carry_reg <= add_cout;
                    if (idx == LAST_IDX) begin
                        idx      <= '0;
                        cout_reg <= add_cout;
                        ovf_reg  <= (a_reg[W-1] == b_reg[W-1]) && (add_sum[BYTE_W-1] != a_reg[W-1]);
                        state    <= ST_DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy = (state == ST_RUN) || (state == ST_DONE);
    assign done = (state == ST_DONE);
    assign sum  = sum_reg;
    assign cout = cout_reg;
    assign ovf  = ovf_reg;

endmodule
